branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor feeding the fetch stage's next-PC mux. Each cycle it looks up the current fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and produces the predicted target plus the final `PCSrc` select. It also resolves branches reaching execute: it updates BTB state and overrides the fetch prediction with a corrective redirect when execute detects a misprediction.

## Interface
- `ENTRIES`, 64: BTB entries; power of two, ≥ 4. `IDX_W = log2(ENTRIES)`. Index is `PC[IDX_W+1:2]`; tag is `PC[31:IDX_W+2]`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; `reset == 0` at a rising edge resets the block.
- `PCF` in 32: current fetch PC.
- `PredTakenF` out 1: fetch-stage prediction; piped down to execute by the pipeline.
- `PredPCTargetF` out 32: predicted target for `PCF`.
- `EnE` in 1: execute instruction is valid and advancing this cycle.
- `BranchE` in 1: execute instruction is a branch or jump.
- `TakenE` in 1: resolved outcome; always 1 for jumps.
- `PredTakenE` in 1: `PredTakenF` carried to execute.
- `PredPCTargetE` in 32: `PredPCTargetF` carried to execute.
- `PCE` in 32: execute instruction PC.
- `PCTargetE` in 32: resolved target.
- `PCSrc` out 2: next-PC select. 00 = `PCPlus4F`, 01 = `PredPCTargetF`, 10 = `PCPlus4E`, 11 = `PCTargetE`.
- `MispredictE` out 1: execute redirect this cycle; the hazard unit flushes decode and execute.

## Operation
- Per-entry state, in flops: `valid`, `tag[31-IDX_W-2:0]`, `target[31:0]`, `ctr[1:0]`. Counter meaning: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Lookup (combinational):
  - `hitF = valid[idx(PCF)] && tag == tag(PCF)`.
  - `PredTakenF = hitF && ctr[1]`.
  - `PredPCTargetF = target[idx(PCF)]` when `hitF`, else 0.
- Misprediction (combinational, only when `EnE`):
  - Case A: `BranchE && TakenE && (!PredTakenE || PredPCTargetE != PCTargetE)` gives `PCSrc = 11`.
  - Case B: `PredTakenE && (!BranchE || !TakenE)` gives `PCSrc = 10`. This covers a not-taken branch and a stale alias hit on a non-branch.
  - `MispredictE` = A or B.
- `PCSrc` priority: execute redirect (11/10) > `PredTakenF` (01) > 00.
- Update, at the edge when `EnE && BranchE`, on `idx(PCE)`:
  - Hit with `TakenE = 1`: `ctr` saturating increment (11 stays 11); `target <= PCTargetE`.
  - Hit with `TakenE = 0`: `ctr` saturating decrement (00 stays 00); target unchanged.
  - Miss with `TakenE = 1`: allocate and overwrite. Set `valid = 1`, tag = `tag(PCE)`, `target = PCTargetE`, `ctr = 10`.
  - Miss with `TakenE = 0`: no change.
- Alias cleanup: when `EnE && !BranchE && PredTakenE` and the entry at `idx(PCE)` hits `tag(PCE)`, set `valid <= 0`.
- Stalls: `EnE = 0` blocks all updates and the redirect. Fetch stall (`StallF`) is external; lookup output simply follows `PCF`.

## Timing
- Reset:
  - All `valid <= 0` and all `ctr <= 01` in one cycle; tags and targets are don't-care.
  - While `reset == 0`, outputs are forced: `PCSrc = 00`, `PredTakenF = 0`, `PredPCTargetF = 0`, `MispredictE = 0`.
  - Reset asserted mid-update wins; no partial write survives.
- Lookup and redirect are zero-latency, combinational in the same cycle.
- Updates are visible to lookups from the cycle after the edge. When `idx(PCF) == idx(PCE)` in the same cycle, the lookup sees pre-update state; no bypass.
- Exactly one entry is written per cycle at most.

## Test plan
1. Reset, then `PCF = 0x100` → `PredTakenF = 0`, `PCSrc = 00`, `PredPCTargetF = 0`.
2. Execute: `PCE = 0x100`, `BranchE = 1`, `TakenE = 1`, `PredTakenE = 0`, `PCTargetE = 0x200`, `EnE = 1` → `PCSrc = 11`, `MispredictE = 1`. Next cycle, `PCF = 0x100` → `PredTakenF = 1`, `PredPCTargetF = 0x200`, `PCSrc = 01`.
3. Counter saturation: three more taken resolutions at 0x100 leave `ctr = 11`. Two not-taken with `PredTakenE = 1` → `PCSrc = 10` each time. The counter goes to 10 after the first, then 01, after which `PredTakenF = 0`.
4. Alias: entry for 0x100 valid; `PCF = 0x500` (same index with `ENTRIES = 64`, different tag) → `PredTakenF = 0`. Then a taken branch at 0x500 → 0x600 replaces the entry, and 0x100 misses.
5. Target mismatch (JALR): `PredTakenE = 1`, `PredPCTargetE = 0x200`, `TakenE = 1`, `PCTargetE = 0x300` → `PCSrc = 11`, and the stored target becomes 0x300.
6. Same-cycle conflict and gating:
   - `idx(PCF) == idx(PCE)` during an allocating update → this cycle `PredTakenF = 0`, next cycle 1.
   - `EnE = 0` with mismatch inputs → `PCSrc` follows the fetch prediction and no state changes.
   - Reset pulled low mid-run → all predictions 0 on the next cycle.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters driving PCSrc and execute redirects
module branch_predictor #(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredPCTargetF,
  input  logic        EnE,
  input  logic        BranchE,
  input  logic        TakenE,
  input  logic        PredTakenE,
  input  logic [31:0] PredPCTargetE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCTargetE,
  output logic [1:0]  PCSrc,
  output logic        MispredictE
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];
  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e, mis_a, mis_b;
  logic             unused_pc;
  assign unused_pc = ^{PCF[1:0], PCE[1:0]};
  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[31:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[31:IDX_W+2];
  assign hit_f = valid_q[idx_f] && tag_q[idx_f] == tag_f;
  assign hit_e = valid_q[idx_e] && tag_q[idx_e] == tag_e;
  assign mis_a = EnE && BranchE && TakenE && (!PredTakenE || PredPCTargetE != PCTargetE);
  assign mis_b = EnE && PredTakenE && (!BranchE || !TakenE);
  assign PredTakenF    = reset && hit_f && ctr_q[idx_f][1];
  assign PredPCTargetF = (reset && hit_f) ? target_q[idx_f] : 32'd0;
  assign MispredictE   = reset && (mis_a || mis_b);
  assign PCSrc = !reset ? 2'b00 : mis_a ? 2'b11 : mis_b ? 2'b10 : PredTakenF ? 2'b01 : 2'b00;
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (EnE && BranchE && hit_e) begin
      ctr_d[idx_e] = TakenE ? (ctr_q[idx_e] == 2'b11 ? 2'b11 : ctr_q[idx_e] + 2'd1)
                            : (ctr_q[idx_e] == 2'b00 ? 2'b00 : ctr_q[idx_e] - 2'd1);
      target_d[idx_e] = TakenE ? PCTargetE : target_q[idx_e];
    end else if (EnE && BranchE && TakenE) begin
      valid_d[idx_e]  = 1'b1;
      tag_d[idx_e]    = tag_e;
      target_d[idx_e] = PCTargetE;
      ctr_d[idx_e]    = 2'b10;
    end else if (EnE && !BranchE && PredTakenE && hit_e) begin
      valid_d[idx_e] = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '{default: 1'b0};
      ctr_q   <= '{default: 2'b01};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench comparing branch_predictor against an abstract BTB model
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredPCTargetF;
  logic        EnE, BranchE, TakenE, PredTakenE;
  logic [31:0] PredPCTargetE, PCE, PCTargetE;
  logic [1:0]  PCSrc;
  logic        MispredictE;
  branch_predictor #(.ENTRIES(64)) dut (
    .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF), .PredPCTargetF(PredPCTargetF),
    .EnE(EnE), .BranchE(BranchE), .TakenE(TakenE), .PredTakenE(PredTakenE),
    .PredPCTargetE(PredPCTargetE), .PCE(PCE), .PCTargetE(PCTargetE),
    .PCSrc(PCSrc), .MispredictE(MispredictE)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit          pt;
    logic [31:0] tgt;
    logic [1:0]  src;
    bit          mis;
    string       nm;
  } exp_t;
  exp_t        sb [$];
  int          checks = 0;
  int          failures = 0;
  bit          m_valid [64];
  int unsigned m_owner [64];
  int unsigned m_tgt   [64];
  int          m_cnt   [64];
  function automatic int slot(input int unsigned pc);
    return int'((pc / 4) % 64);
  endfunction
  function automatic bit owns(input int unsigned pc);
    return m_valid[slot(pc)] && (m_owner[slot(pc)] / 256 == pc / 256);
  endfunction
  task automatic step(input bit rst_i, en, br, tk, pte, input int unsigned ppte, pce, pcte, pcf,
                      input string nm);
    exp_t e;
    int   j;
    reset = rst_i; EnE = en; BranchE = br; TakenE = tk; PredTakenE = pte;
    PredPCTargetE = ppte; PCE = pce; PCTargetE = pcte; PCF = pcf;
    e.nm  = nm;
    e.pt  = rst_i && owns(pcf) && m_cnt[slot(pcf)] >= 2;
    e.tgt = (rst_i && owns(pcf)) ? m_tgt[slot(pcf)] : 0;
    e.mis = 0;
    e.src = e.pt ? 2'b01 : 2'b00;
    if (rst_i && en && br && tk && (!pte || ppte != pcte)) begin
      e.src = 2'b11; e.mis = 1;
    end else if (rst_i && en && pte && !(br && tk)) begin
      e.src = 2'b10; e.mis = 1;
    end
    sb.push_back(e);
    @(posedge clk);
    j = slot(pce);
    if (!rst_i) begin
      for (int k = 0; k < 64; k++) begin
        m_valid[k] = 0; m_cnt[k] = 1;
      end
    end else if (en && br && owns(pce)) begin
      if (tk) begin
        m_cnt[j] = (m_cnt[j] + 1 > 3) ? 3 : m_cnt[j] + 1;
        m_tgt[j] = pcte;
      end else begin
        m_cnt[j] = (m_cnt[j] - 1 < 0) ? 0 : m_cnt[j] - 1;
      end
    end else if (en && br && tk) begin
      m_valid[j] = 1; m_owner[j] = pce; m_tgt[j] = pcte; m_cnt[j] = 2;
    end else if (en && !br && pte && owns(pce)) begin
      m_valid[j] = 0;
    end
    #1;
  endtask
  task automatic fetch(input int unsigned pcf, input string nm);
    step(1, 0, 0, 0, 0, 0, 0, 0, pcf, nm);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks += 4;
        if (PredTakenF !== e.pt) begin
          failures++; $display("FAIL %s PredTakenF got %0b exp %0b", e.nm, PredTakenF, e.pt);
        end
        if (PredPCTargetF !== e.tgt) begin
          failures++; $display("FAIL %s PredPCTargetF got %h exp %h", e.nm, PredPCTargetF, e.tgt);
        end
        if (PCSrc !== e.src) begin
          failures++; $display("FAIL %s PCSrc got %b exp %b", e.nm, PCSrc, e.src);
        end
        if (MispredictE !== e.mis) begin
          failures++; $display("FAIL %s MispredictE got %0b exp %0b", e.nm, MispredictE, e.mis);
        end
      end
    end
  end
  initial begin
    int unsigned pool [6];
    int unsigned pce, pcte, ppte;
    int          waited;
    bit          br, tk, pte;
    reset = 0; EnE = 0; BranchE = 0; TakenE = 0; PredTakenE = 0;
    PredPCTargetE = 0; PCE = 0; PCTargetE = 0; PCF = 0;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h100, "reset0");
    step(0, 1, 1, 1, 0, 0, 32'h100, 32'h200, 32'h100, "reset1");
    fetch(32'h100, "post_reset");
    step(1, 1, 1, 1, 0, 0, 32'h100, 32'h200, 32'h100, "alloc_same_cycle");
    fetch(32'h100, "alloc_visible");
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1, 32'h200, 32'h100, 32'h200, 32'h100, "taken_sat");
    step(1, 1, 1, 0, 1, 32'h200, 32'h100, 32'h200, 32'h100, "nt1");
    step(1, 1, 1, 0, 1, 32'h200, 32'h100, 32'h200, 32'h100, "nt2");
    fetch(32'h100, "weak_nt_lookup");
    fetch(32'h500, "alias_miss");
    step(1, 1, 1, 1, 0, 0, 32'h500, 32'h600, 32'h500, "alias_alloc");
    fetch(32'h100, "replaced_miss");
    fetch(32'h500, "new_owner_hit");
    step(1, 1, 1, 1, 1, 32'h200, 32'h500, 32'h300, 32'h500, "jalr_mismatch");
    fetch(32'h500, "jalr_target");
    step(1, 0, 1, 1, 1, 32'h200, 32'h500, 32'h700, 32'h500, "ene_gated");
    fetch(32'h500, "ene_no_change");
    step(1, 1, 0, 0, 1, 32'h300, 32'h500, 32'h504, 32'h500, "alias_cleanup");
    fetch(32'h500, "cleanup_miss");
    step(1, 1, 1, 1, 0, 0, 32'h100, 32'h200, 32'h100, "realloc");
    step(0, 1, 1, 1, 1, 32'h900, 32'h100, 32'h900, 32'h100, "reset_mid_update");
    fetch(32'h100, "after_mid_reset");
    pool = '{32'h100, 32'h500, 32'h104, 32'h904, 32'h2100, 32'h0};
    for (int i = 0; i < 3000; i++) begin
      pool[5] = $urandom & 32'hFFFF_FFFC;
      pce  = pool[$urandom_range(0, 5)];
      pcte = pool[$urandom_range(0, 5)] + 32'h40;
      ppte = $urandom_range(0, 1) ? pcte : pool[$urandom_range(0, 5)];
      br = $urandom_range(0, 3) != 0;
      tk = $urandom_range(0, 1);
      pte = $urandom_range(0, 1);
      step($urandom_range(0, 199) != 0, $urandom_range(0, 4) != 0, br, tk, pte, ppte, pce, pcte,
           pool[$urandom_range(0, 5)], "random");
    end
    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain pending got %0d exp 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
